// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier (NxN -> 2N, signed/unsigned), one Booth step per cycle.
// Latency N+1 cycles from accepted start to done; start is ignored while busy, result holds until the next product.
module booth_seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [2*N-1:0] result,
  output logic           busy,
  output logic           done
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     q_q, q_d;
  logic [W:0]       acc_q, acc_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   res_q, res_d;

  logic [W:0]       m_sx;
  logic [W:0]       acc_sum;
  logic [W:0]       acc_sh;
  logic [W-1:0]     q_sh;

  // One Booth step: conditional add/subtract, then arithmetic shift of {A, Q, q_m1}.
  always_comb begin
    m_sx = {m_q[W-1], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + m_sx;
      2'b10:   acc_sum = acc_q - m_sx;
      default: acc_sum = acc_q;
    endcase
    acc_sh = {acc_sum[W], acc_sum[W:1]};
    q_sh   = {acc_sum[0], q_q[W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          m_d     = {signed_mode & a_in[N-1], a_in};
          q_d     = {signed_mode & b_in[N-1], b_in};
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(W);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        // Final step: low 2N bits of {A, Q} are the exact product in either mode.
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = {acc_sh[N-2:0], q_sh};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign result = res_q;
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);

endmodule
